// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: CSR addresses, trap cause codes, mstatus bit positions and request types shared by trap_ctrl.
package trap_ctrl_pkg;

  localparam logic [31:0] CSR_MSTATUS  = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC    = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC     = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE   = 32'h0000_0342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_TRAP,
    REQ_MRET
  } req_kind_e;

  typedef struct packed {
    logic        accept;
    req_kind_e   kind;
    logic [31:0] cause;
  } trap_req_t;

  // Trap entry: the old interrupt enable is saved in MPIE and interrupts are masked.
  function automatic logic [31:0] trap_status(input logic [31:0] s);
    logic [31:0] r;
    r           = s;
    r[MPIE_BIT] = s[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // Trap exit: the saved enable is restored and MPIE is set back to 1.
  function automatic logic [31:0] mret_status(input logic [31:0] s);
    logic [31:0] r;
    r           = s;
    r[MIE_BIT]  = s[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_req_arb.sv
// trap_req_arb: combinational priority encoder for requests seen while the sequencer is idle.
module trap_req_arb
  import trap_ctrl_pkg::*;
(
  input  logic      i_ecall,
  input  logic      i_ebreak,
  input  logic      i_mret,
  input  logic      i_ex_jump,
  input  logic      i_ex_hold,
  input  logic      i_irq,
  input  logic      i_mie,
  output trap_req_t o_req
);

  logic w_sync_trap;
  logic w_irq_ok;

  // An interrupt never preempts a redirect or a stalled instruction, and needs MIE.
  assign w_irq_ok    = i_irq & i_mie & ~i_ex_jump & ~i_ex_hold;
  assign w_sync_trap = i_ecall | i_ebreak;

  // Priority: ecall/ebreak, then mret, then (ex_jump blocks irq above), then irq.
  always_comb begin
    o_req.accept = w_sync_trap | i_mret | w_irq_ok;
    o_req.kind   = (w_sync_trap | (~i_mret & w_irq_ok)) ? REQ_TRAP :
                   i_mret ? REQ_MRET : REQ_NONE;
    o_req.cause  = i_ecall  ? CAUSE_ECALL  :
                   i_ebreak ? CAUSE_EBREAK :
                   w_irq_ok ? CAUSE_IRQ    : 32'h0;
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: merges pipeline hold/jump requests and sequences machine-mode trap entry and mret exit.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TVEC_ALIGN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_jump_flag_i,
  input  logic [XLEN-1:0] ex_jump_addr_i,
  input  logic            ex_hold_flag_i,
  input  logic            bus_hold_flag_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic            irq_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  output logic            hold_flag_o,
  output logic            jump_flag_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            csr_we_o,
  output logic [XLEN-1:0] csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            busy_o
);

  localparam logic [XLEN-1:0] TVEC_MASK = ~((XLEN'(1) << TVEC_ALIGN) - XLEN'(1));

  typedef enum logic [6:0] {
    S_IDLE        = 7'b000_0001,
    S_MEPC        = 7'b000_0010,
    S_MSTATUS     = 7'b000_0100,
    S_MCAUSE      = 7'b000_1000,
    S_JUMP        = 7'b001_0000,
    S_MRET_STATUS = 7'b010_0000,
    S_MRET_JUMP   = 7'b100_0000
  } state_e;

  state_e          r_state;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_status;

  trap_req_t w_req;
  logic      w_idle;
  logic      w_accept;
  logic      w_pass;
  logic      w_csr_state;
  logic      w_tvec_jump;
  logic      w_mepc_jump;

  trap_req_arb u_arb (
    .i_ecall   (ecall_i),
    .i_ebreak  (ebreak_i),
    .i_mret    (mret_i),
    .i_ex_jump (ex_jump_flag_i),
    .i_ex_hold (ex_hold_flag_i),
    .i_irq     (irq_i),
    .i_mie     (csr_mstatus_i[MIE_BIT]),
    .o_req     (w_req)
  );

  // Requests only count in IDLE and out of reset, so reset leaves hold reflecting the stall inputs alone.
  assign w_idle      = (r_state == S_IDLE) & rst_n;
  assign w_accept    = w_idle & w_req.accept;
  assign w_pass      = w_idle & ex_jump_flag_i & ~w_req.accept;
  assign w_csr_state = (r_state == S_MEPC) | (r_state == S_MSTATUS) |
                       (r_state == S_MCAUSE) | (r_state == S_MRET_STATUS);
  assign w_tvec_jump = (r_state == S_JUMP) & ~bus_hold_flag_i;
  assign w_mepc_jump = (r_state == S_MRET_JUMP) & ~bus_hold_flag_i;

  // Sequencer: one CSR write per state, jump states wait out bus stalls before returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cause  <= '0;
      r_epc    <= '0;
      r_status <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req.accept) begin
            r_status <= csr_mstatus_i;
            if (w_req.kind == REQ_TRAP) begin
              r_cause <= w_req.cause;
              r_epc   <= inst_addr_i;
              r_state <= S_MEPC;
            end else begin
              r_state <= S_MRET_STATUS;
            end
          end
        end
        S_MEPC:        r_state <= S_MSTATUS;
        S_MSTATUS:     r_state <= S_MCAUSE;
        S_MCAUSE:      r_state <= S_JUMP;
        S_JUMP:        r_state <= bus_hold_flag_i ? S_JUMP : S_IDLE;
        S_MRET_STATUS: r_state <= S_MRET_JUMP;
        S_MRET_JUMP:   r_state <= bus_hold_flag_i ? S_MRET_JUMP : S_IDLE;
        default:       r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode: pass-through redirect in IDLE, otherwise driven purely by the state registers.
  always_comb begin
    hold_flag_o = ex_hold_flag_i | bus_hold_flag_i | w_csr_state | w_accept;
    jump_flag_o = w_pass | w_tvec_jump | w_mepc_jump;
    jump_addr_o = w_pass      ? ex_jump_addr_i :
                  w_tvec_jump ? (csr_mtvec_i & TVEC_MASK) :
                  w_mepc_jump ? csr_mepc_i : '0;
    csr_we_o    = w_csr_state;
    csr_waddr_o = (r_state == S_MEPC)   ? CSR_MEPC :
                  (r_state == S_MCAUSE) ? CSR_MCAUSE :
                  ((r_state == S_MSTATUS) | (r_state == S_MRET_STATUS)) ? CSR_MSTATUS : '0;
    csr_wdata_o = (r_state == S_MEPC)        ? r_epc :
                  (r_state == S_MSTATUS)     ? trap_status(r_status) :
                  (r_state == S_MCAUSE)      ? r_cause :
                  (r_state == S_MRET_STATUS) ? mret_status(r_status) : '0;
    busy_o      = r_state != S_IDLE;
  end

endmodule
